seqdet_sched: RTL and testbench

- Controller that sequences a serial pattern detector from a parallel word stream.
- Accepts WORD_W-bit words over a valid/ready handshake and serializes each word MSB first, one bit per cycle.
- Runs every bit through a programmable-length pattern matcher, with overlapping or non-overlapping matches.
- Reports a per-bit match strobe and a saturating match count per job; it sits between a word-oriented producer and the serial-detection datapath.

---
 rtl/seqdet_sched.sv | 209 ++++++++++++++++++++
 tb/tb_seqdet_sched.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seqdet_sched.sv
// Word-to-serial pattern detection controller: accepts words over valid/ready,
// shifts them out MSB first and counts matches of a programmable pattern per job.
module seqdet_sched #(
  parameter int WORD_W = 8,
  parameter int PAT_W  = 5,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic [2:0]        cfg_len,
  input  logic              cfg_overlap,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              x_out,
  output logic              x_vld,
  output logic              z,
  output logic [CNT_W-1:0]  match_cnt,
  output logic              busy,
  output logic              done
);

  localparam int IDX_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int SEEN_W = $clog2(PAT_W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [PAT_W-1:0]    pat_q, pat_d;
  logic [2:0]          len_q, len_d;
  logic                ovl_q, ovl_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic                last_q, last_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [PAT_W-1:0]    hist_q, hist_d;
  logic [SEEN_W-1:0]   seen_q, seen_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                x_out_q, x_out_d;
  logic                x_vld_q, x_vld_d;
  logic                z_q, z_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;

  logic [2:0]          len_clamp_s;
  logic                bit_s;
  logic [PAT_W-1:0]    hist_new_s;
  logic [SEEN_W-1:0]   seen_inc_s;
  logic [PAT_W-1:0]    mask_s;
  logic                match_s;
  logic [CNT_W-1:0]    cnt_sat_s;

  // Clamp requested length into 1..PAT_W
  always_comb begin
    len_clamp_s = cfg_len;
    if (cfg_len == 3'd0) begin
      len_clamp_s = 3'd1;
    end else if (32'(cfg_len) > PAT_W) begin
      len_clamp_s = 3'(PAT_W);
    end else begin
      len_clamp_s = cfg_len;
    end
  end

  // Matcher datapath: next history, saturating bit count, compare under length mask
  always_comb begin
    bit_s      = word_q[idx_q];
    hist_new_s = {hist_q[PAT_W-2:0], bit_s};
    if (seen_q == SEEN_W'(PAT_W)) begin
      seen_inc_s = seen_q;
    end else begin
      seen_inc_s = seen_q + SEEN_W'(1);
    end
    for (int i = 0; i < PAT_W; i++) begin
      mask_s[i] = (32'(i) < 32'(len_q));
    end
    match_s = (32'(seen_inc_s) >= 32'(len_q)) &&
              ((hist_new_s & mask_s) == (pat_q & mask_s));
    if (cnt_q == {CNT_W{1'b1}}) begin
      cnt_sat_s = cnt_q;
    end else begin
      cnt_sat_s = cnt_q + CNT_W'(1);
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    word_d  = word_q;
    last_d  = last_q;
    idx_d   = idx_q;
    hist_d  = hist_q;
    seen_d  = seen_q;
    cnt_d   = cnt_q;
    x_out_d = x_out_q;
    x_vld_d = 1'b0;
    z_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          pat_d   = cfg_pattern;
          len_d   = len_clamp_s;
          ovl_d   = cfg_overlap;
          cnt_d   = '0;
          hist_d  = '0;
          seen_d  = '0;
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (in_valid) begin
          word_d  = in_data;
          last_d  = in_last;
          idx_d   = IDX_W'(WORD_W - 1);
          state_d = SHIFT;
        end else begin
          state_d = LOAD;
        end
      end
      SHIFT: begin
        x_out_d = bit_s;
        x_vld_d = 1'b1;
        hist_d  = hist_new_s;
        z_d     = match_s;
        if (match_s) begin
          cnt_d  = cnt_sat_s;
          // Non-overlapping mode forces a full fresh pattern before the next hit
          seen_d = ovl_q ? seen_inc_s : '0;
        end else begin
          seen_d = seen_inc_s;
        end
        if (idx_q == '0) begin
          state_d = last_q ? DONE : LOAD;
        end else begin
          idx_d   = idx_q - IDX_W'(1);
          state_d = SHIFT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State, configuration, datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pat_q   <= '0;
      len_q   <= 3'd1;
      ovl_q   <= 1'b0;
      word_q  <= '0;
      last_q  <= 1'b0;
      idx_q   <= '0;
      hist_q  <= '0;
      seen_q  <= '0;
      cnt_q   <= '0;
      x_out_q <= 1'b0;
      x_vld_q <= 1'b0;
      z_q     <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      word_q  <= word_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      hist_q  <= hist_d;
      seen_q  <= seen_d;
      cnt_q   <= cnt_d;
      x_out_q <= x_out_d;
      x_vld_q <= x_vld_d;
      z_q     <= z_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign in_ready  = (state_q == LOAD);
  assign x_out     = x_out_q;
  assign x_vld     = x_vld_q;
  assign z         = z_q;
  assign match_cnt = cnt_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_seqdet_sched.sv
// Bench for seqdet_sched: a stream-level match model checked every cycle against
// two instances (default count width and a 2-bit count), plus literal job results.
module tb_seqdet_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [4:0] cfg_pattern = 5'd0;
  logic [2:0] cfg_len = 3'd0;
  logic       cfg_overlap = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_last = 1'b0;

  logic       in_ready, x_out, x_vld, z, busy, done;
  logic [7:0] match_cnt;
  logic       in_ready_2, x_out_2, x_vld_2, z_2, busy_2, done_2;
  logic [1:0] match_cnt_2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seqdet_sched dut (
    .clk(clk), .rst(rst), .start(start), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid),
    .in_data(in_data), .in_last(in_last), .in_ready(in_ready), .x_out(x_out),
    .x_vld(x_vld), .z(z), .match_cnt(match_cnt), .busy(busy), .done(done)
  );

  seqdet_sched #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid),
    .in_data(in_data), .in_last(in_last), .in_ready(in_ready_2), .x_out(x_out_2),
    .x_vld(x_vld_2), .z(z_2), .match_cnt(match_cnt_2), .busy(busy_2), .done(done_2)
  );

  // Model: the job is a bit stream; bit n completes a match when the last len bits
  // equal the pattern and (non-overlap) at least len bits followed the previous match.
  int         m_mode;     // 0 idle, 1 waiting for word, 2 emitting bits, 3 job end
  logic [7:0] m_word;
  logic       m_last;
  int         m_k;
  logic [4:0] m_pat;
  int         m_len;
  logic       m_ovl;
  int         m_nbits;
  int         m_lastend;
  logic [31:0] m_recent;
  int         m_cnt;
  logic       e_x, e_vld, e_z;
  logic       mdl_hit;

  function automatic logic f_match(input logic [31:0] hist, input int n, input int le,
                                   input int len, input logic [4:0] pat);
    logic [31:0] mask;
    mask = (32'd1 << len) - 32'd1;
    return ((n - le) >= len) && ((hist & mask) == ({27'd0, pat} & mask));
  endfunction

  always_comb mdl_hit = f_match({m_recent[30:0], m_word[m_k]}, m_nbits + 1, m_lastend, m_len, m_pat);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode <= 0; m_word <= 8'd0; m_last <= 1'b0; m_k <= 0; m_pat <= 5'd0;
      m_len <= 1; m_ovl <= 1'b0; m_nbits <= 0; m_lastend <= 0; m_recent <= 32'd0;
      m_cnt <= 0; e_x <= 1'b0; e_vld <= 1'b0; e_z <= 1'b0;
    end else begin
      e_vld <= 1'b0;
      e_z   <= 1'b0;
      case (m_mode)
        0: if (start) begin
          m_pat <= cfg_pattern;
          m_len <= (cfg_len == 3'd0) ? 1 : ((int'(cfg_len) > 5) ? 5 : int'(cfg_len));
          m_ovl <= cfg_overlap;
          m_cnt <= 0; m_nbits <= 0; m_lastend <= 0; m_recent <= 32'd0;
          m_mode <= 1;
        end
        1: if (in_valid) begin
          m_word <= in_data; m_last <= in_last; m_k <= 7; m_mode <= 2;
        end
        2: begin
          e_vld    <= 1'b1;
          e_x      <= m_word[m_k];
          e_z      <= mdl_hit;
          m_recent <= {m_recent[30:0], m_word[m_k]};
          m_nbits  <= m_nbits + 1;
          if (mdl_hit) begin
            m_cnt <= m_cnt + 1;
            if (!m_ovl) m_lastend <= m_nbits + 1;
          end
          if (m_k == 0) m_mode <= m_last ? 3 : 1;
          else m_k <= m_k - 1;
        end
        default: m_mode <= 0;
      endcase
    end
  end

  int cyc = 0, nx = 0, ndone = 0, nrdy = 0, first_x = 0, s_cyc = 0, v_cyc = 0;
  logic [15:0] xseq = 16'd0, zseq = 16'd0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: compare on the falling edge, then return just after the rising edge.
  task automatic tick();
    @(negedge clk);
    if (!rst) begin
      chk("in_ready",   int'(in_ready),   int'(m_mode == 1));
      chk("busy",       int'(busy),       int'(m_mode != 0));
      chk("done",       int'(done),       int'(m_mode == 3));
      chk("x_vld",      int'(x_vld),      int'(e_vld));
      chk("z",          int'(z),          int'(e_z));
      chk("match_cnt",  int'(match_cnt),  (m_cnt > 255) ? 255 : m_cnt);
      chk("in_ready_2", int'(in_ready_2), int'(m_mode == 1));
      chk("busy_2",     int'(busy_2),     int'(m_mode != 0));
      chk("done_2",     int'(done_2),     int'(m_mode == 3));
      chk("x_vld_2",    int'(x_vld_2),    int'(e_vld));
      chk("z_2",        int'(z_2),        int'(e_z));
      chk("match_cnt_2", int'(match_cnt_2), (m_cnt > 3) ? 3 : m_cnt);
      if (e_vld) begin
        chk("x_out",   int'(x_out),   int'(e_x));
        chk("x_out_2", int'(x_out_2), int'(e_x));
      end
    end
    if (x_vld) begin
      if (nx == 0) first_x = cyc;
      xseq = {xseq[14:0], x_out};
      zseq = {zseq[14:0], z};
      nx++;
    end
    if (done) ndone++;
    if (in_ready) nrdy++;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input logic [4:0] pat, input logic [2:0] len, input logic ovl,
                         input int nw, input logic [7:0] w0, input logic [7:0] w1,
                         input int stall, input bit ign);
    int c;
    nx = 0; ndone = 0; nrdy = 0; xseq = 16'd0; zseq = 16'd0;
    start = 1'b1; cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl;
    s_cyc = cyc;
    tick();
    start = 1'b0; cfg_pattern = ~pat; cfg_len = 3'd3; cfg_overlap = ~ovl;
    for (int i = 0; i < nw; i++) begin
      if (i == 0) begin
        for (int s = 0; s < stall; s++) begin
          chk("stall_ready", int'(in_ready), 1);
          chk("stall_busy",  int'(busy), 1);
          chk("stall_xvld",  int'(x_vld), 0);
          in_data = 8'hA5;
          tick();
        end
      end
      in_valid = 1'b1; in_data = (i == 0) ? w0 : w1; in_last = (i == nw - 1);
      v_cyc = cyc;
      tick();
      in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
      if (ign) begin
        start = 1'b1; cfg_pattern = 5'b00001; cfg_len = 3'd1; cfg_overlap = 1'b1;
        tick();
        start = 1'b0;
      end
      if (i < nw - 1) begin
        c = 0;
        while (!in_ready && c < 40) begin tick(); c++; end
        chk("ready_seen", int'(in_ready), 1);
      end
    end
    c = 0;
    while (ndone == 0 && c < 40) begin tick(); c++; end
    chk("done_seen", ndone, 1);
    tick();
    tick();
  endtask

  initial begin
    // Reset state
    #1 rst = 1'b1;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(in_ready), 0);
    chk("rst_xvld", int'(x_vld), 0);
    chk("rst_cnt", int'(match_cnt), 0);
    chk("rst_done", int'(done), 0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    tick();

    // Overlapping: 0x92 against 10010
    run_job(5'b10010, 3'd5, 1'b1, 1, 8'h92, 8'h00, 0, 1'b0);
    chk("A_bits", int'(xseq[7:0]), 8'h92);
    chk("A_zpos", int'(zseq[7:0]), 8'b00001001);
    chk("A_nx", nx, 8);
    chk("A_done", ndone, 1);
    chk("A_cnt", int'(match_cnt), 2);
    chk("A_latency", first_x - s_cyc, 3);

    // Non-overlapping: same stream
    run_job(5'b10010, 3'd5, 1'b0, 1, 8'h92, 8'h00, 0, 1'b0);
    chk("B_zpos", int'(zseq[7:0]), 8'b00001000);
    chk("B_cnt", int'(match_cnt), 1);

    // Match spanning a word boundary: 0x05, 0x40 against 101
    run_job(5'b00101, 3'd3, 1'b1, 2, 8'h05, 8'h40, 0, 1'b0);
    chk("C_bits", int'(xseq), 16'h0540);
    chk("C_zpos", int'(zseq), 16'h0140);
    chk("C_cnt", int'(match_cnt), 2);
    chk("C_rdy_cycles", nrdy, 2);

    // Length 0 clamps to 1; 2-bit counter saturates
    run_job(5'b00001, 3'd0, 1'b1, 1, 8'hFF, 8'h00, 0, 1'b0);
    chk("D_zpos", int'(zseq[7:0]), 8'hFF);
    chk("D_cnt8", int'(match_cnt), 8);
    chk("D_cnt2", int'(match_cnt_2), 3);
    tick(); tick();
    chk("D_hold", int'(match_cnt), 8);

    // Length above PAT_W clamps to 5
    run_job(5'b10010, 3'd7, 1'b1, 1, 8'h92, 8'h00, 0, 1'b0);
    chk("E_cnt", int'(match_cnt), 2);

    // Producer stall plus an ignored start during shifting
    run_job(5'b10010, 3'd5, 1'b1, 1, 8'h92, 8'h00, 5, 1'b1);
    chk("F_zpos", int'(zseq[7:0]), 8'b00001001);
    chk("F_cnt", int'(match_cnt), 2);
    chk("F_resume", first_x - v_cyc, 2);
    chk("F_busy_after", int'(busy), 0);

    // Asynchronous reset in the middle of a job (pattern 100 hits on bit 3)
    nx = 0;
    start = 1'b1; cfg_pattern = 5'b00100; cfg_len = 3'd3; cfg_overlap = 1'b1;
    tick();
    start = 1'b0; in_valid = 1'b1; in_data = 8'h92; in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    for (int c = 0; c < 20 && nx < 4; c++) tick();
    chk("G_nx_before_rst", nx, 4);
    chk("G_cnt_before_rst", int'(match_cnt), 1);
    rst = 1'b1;
    #1;
    chk("G_rst_busy", int'(busy), 0);
    chk("G_rst_xvld", int'(x_vld), 0);
    chk("G_rst_xout", int'(x_out), 0);
    chk("G_rst_z", int'(z), 0);
    chk("G_rst_cnt", int'(match_cnt), 0);
    chk("G_rst_ready", int'(in_ready), 0);
    chk("G_rst_cnt2", int'(match_cnt_2), 0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    tick(); tick();
    chk("G_idle_ready", int'(in_ready), 0);

    // Fresh job after reset behaves like the first
    run_job(5'b10010, 3'd5, 1'b1, 1, 8'h92, 8'h00, 0, 1'b0);
    chk("H_zpos", int'(zseq[7:0]), 8'b00001001);
    chk("H_cnt", int'(match_cnt), 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
